reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 8 +
 rtl/reg_file_if.sv | 23 ++
 rtl/reg_word.sv | 25 ++
 rtl/reg_file.sv | 72 +++++++
 tb/tb_reg_file.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and index type for the register file slice.
package reg_file_pkg;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = $clog2(NREGS);

    typedef logic [REG_AW-1:0] reg_idx_t;
endpackage

// File: rtl/reg_file_if.sv
// Write/read bundle for reg_file; the driver side uses master, the file side uses slave.
interface reg_file_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
);
    logic             WriteEn;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr_a;
    logic [WIDTH-1:0] rd_data_a;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_b;
    logic [15:0]      wr_count;

    modport master (
        output WriteEn, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wr_count
    );
    modport slave (
        input  WriteEn, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wr_count
    );
endinterface

// File: rtl/reg_word.sv
// One storage word: loads d on a rising clk edge when WriteEn, cleared asynchronously by reset.
module reg_word #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             WriteEn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (WriteEn) data_d = d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q = data_q;
endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with saturating write counter.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH    = XLEN,
    parameter int unsigned DEPTH    = NREGS,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       WriteEn,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_a,
    output logic [WIDTH-1:0]           rd_data_a,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_b,
    output logic [WIDTH-1:0]           rd_data_b,
    output logic [15:0]                wr_count
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned FIRST = (ZERO_REG == 1) ? 1 : 0;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] word_we;
    logic             wr_commit;
    logic [15:0]      wr_count_q;
    logic [15:0]      wr_count_d;

    // A write only commits when it targets real storage; this also gates the counter.
    always_comb begin
        wr_commit = WriteEn && (32'(wr_addr) < DEPTH);
        if ((ZERO_REG == 1) && (wr_addr == '0)) wr_commit = 1'b0;
        word_we = '0;
        if (wr_commit) word_we[wr_addr] = 1'b1;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (i < FIRST) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_store
            reg_word #(.WIDTH(WIDTH)) u_word (
                .clk     (clk),
                .reset   (reset),
                .WriteEn (word_we[i]),
                .d       (wr_data),
                .q       (regs[i])
            );
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_data_b = regs[rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
        if (!reset && wr_commit && (rd_addr_a == wr_addr)) rd_data_a = wr_data;
        if (!reset && wr_commit && (rd_addr_b == wr_addr)) rd_data_b = wr_data;
`endif
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_commit && (wr_count_q != '1)) wr_count_d = wr_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_count_q <= '0;
        else       wr_count_q <= wr_count_d;
    end

    assign wr_count = wr_count_q;
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file; expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file;
    logic clk;
    logic reset;

    reg_file_if #(.WIDTH(32), .AW(5)) bus ();

    reg_file dut (
        .clk       (clk),
        .reset     (reset),
        .WriteEn   (bus.WriteEn),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .rd_addr_a (bus.rd_addr_a),
        .rd_data_a (bus.rd_data_a),
        .rd_addr_b (bus.rd_addr_b),
        .rd_data_b (bus.rd_data_b),
        .wr_count  (bus.wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int unsigned port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push_exp(input string name, input int unsigned port, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic sample();
        -> sample_ev;
        #1;
    endtask

    task automatic check_reg(input string name, input logic [4:0] idx, input logic [31:0] exp);
        bus.rd_addr_a = idx;
        bus.rd_addr_b = idx;
        #1;
        push_exp({name, "_a"}, 0, exp);
        push_exp({name, "_b"}, 1, exp);
        sample();
    endtask

    task automatic check_count(input string name, input logic [15:0] exp);
        #1;
        push_exp(name, 2, {16'h0, exp});
        sample();
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.WriteEn = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(posedge clk);
        #1;
        bus.WriteEn = 1'b0;
    endtask

    // Monitor: compares every queued expectation against the outputs at the sample point.
    initial begin : monitor
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.port)
                    0:       act = bus.rd_data_a;
                    1:       act = bus.rd_data_b;
                    default: act = {16'h0, bus.wr_count};
                endcase
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] x7_exp;
        reset         = 1'b1;
        bus.WriteEn   = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        repeat (2) @(posedge clk);
        check_reg("in_reset_x5", 5'd5, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) check_reg($sformatf("reset_x%0d", i), 5'(i), 32'h0);
        check_count("reset_count", 16'h0);

        write_reg(5'd5, 32'hDEADBEEF);
        check_reg("x5_write", 5'd5, 32'hDEADBEEF);
        check_count("x5_count", 16'd1);

        write_reg(5'd0, 32'h12345678);
        check_reg("x0_discard", 5'd0, 32'h0);
        check_count("x0_count", 16'd1);

        @(negedge clk);
        bus.wr_addr = 5'd5;
        bus.wr_data = 32'hCAFEF00D;
        @(posedge clk);
        check_reg("we0_x5_hold", 5'd5, 32'hDEADBEEF);
        check_count("we0_count", 16'd1);

        write_reg(5'd7, 32'h11111111);
        check_count("x7_first_count", 16'd2);
        @(negedge clk);
        bus.WriteEn   = 1'b1;
        bus.wr_addr   = 5'd7;
        bus.wr_data   = 32'hA5A5A5A5;
`ifdef REG_FILE_BYPASS_EN
        x7_exp = 32'hA5A5A5A5;
`else
        x7_exp = 32'h11111111;
`endif
        check_reg("x7_same_cycle", 5'd7, x7_exp);
        @(posedge clk);
        #1;
        bus.WriteEn = 1'b0;
        check_reg("x7_next_cycle", 5'd7, 32'hA5A5A5A5);
        check_count("x7_count", 16'd3);

        @(negedge clk);
        bus.WriteEn = 1'b1;
        bus.wr_addr = 5'd0;
        bus.wr_data = 32'hFFFFFFFF;
        check_reg("x0_same_cycle", 5'd0, 32'h0);
        @(posedge clk);
        #1;
        bus.WriteEn = 1'b0;
        check_count("x0_bypass_count", 16'd3);

        write_reg(5'd9, 32'h1);
        check_reg("x9_write", 5'd9, 32'h1);
        check_count("x9_count", 16'd4);
        @(negedge clk);
        reset = 1'b1;
        check_reg("x9_async_reset", 5'd9, 32'h0);
        check_count("async_reset_count", 16'h0);
        check_reg("x5_async_reset", 5'd5, 32'h0);

        @(negedge clk);
        bus.WriteEn = 1'b1;
        bus.wr_addr = 5'd9;
        bus.wr_data = 32'h000000FF;
        check_reg("x9_write_in_reset_same", 5'd9, 32'h0);
        @(posedge clk);
        #1;
        bus.WriteEn = 1'b0;
        check_reg("x9_write_in_reset", 5'd9, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        write_reg(5'd9, 32'h00000042);
        check_reg("x9_after_reset", 5'd9, 32'h00000042);
        check_count("after_reset_count", 16'd1);

        @(negedge clk);
        force dut.wr_count_d = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.wr_count_d;
        check_count("count_preset", 16'hFFFE);
        write_reg(5'd3, 32'h3);
        check_count("sat_write1", 16'hFFFF);
        write_reg(5'd3, 32'h4);
        check_count("sat_write2", 16'hFFFF);
        write_reg(5'd3, 32'h5);
        check_count("sat_write3", 16'hFFFF);
        check_reg("x3_after_sat", 5'd3, 32'h5);

        repeat (10) if (sb.size() > 0) #1;
        if (sb.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
